fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and imem.
// One request in flight at a time: req/addr held until ready; a response is flagged by rvalid.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Architectural PC register plus single-outstanding instruction fetch.
// Instr/InstrValid are held until the core retires the instruction, then next_PC is committed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      next_PC,
  input  logic             Stall,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic             AddrErr,
  output logic [CNT_W-1:0] RetireCount,
  fetch_unit_if.master     imem
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t state, state_nxt;
  logic   capture, commit, aligned;

  assign aligned   = (next_PC[1:0] == 2'b00);
  assign PCPlus4   = PC + 32'd4;
  assign imem.addr = PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // req is decoded from the state register only, so it drops with async reset
  always_comb begin
    state_nxt = state;
    imem.req  = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        imem.req = 1'b1;
        if (imem.ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!Stall) begin
          commit    = 1'b1;
          state_nxt = aligned ? S_REQ : S_ERR;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      Instr       <= 32'h0;
      InstrValid  <= 1'b0;
      AddrErr     <= 1'b0;
      RetireCount <= '0;
    end else begin
      if (capture) begin
        Instr      <= imem.rdata;
        InstrValid <= 1'b1;
      end
      // a misaligned target still retires the faulting instruction
      if (commit) begin
        InstrValid  <= 1'b0;
        RetireCount <= RetireCount + CNT_W'(1);
        if (aligned) PC      <= next_PC;
        else         AddrErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level model of PC/fetch/retire
// behaviour plus a memory responder with configurable ready and response delays.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_PC, PC, PCPlus4, Instr, RetireCount;
  logic        Stall, InstrValid, AddrErr;

  fetch_unit_if imem();

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .next_PC(next_PC), .Stall(Stall),
    .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .InstrValid(InstrValid),
    .AddrErr(AddrErr), .RetireCount(RetireCount), .imem(imem)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: fetch outstanding / instruction held / fault, at transaction level
  logic [31:0] m_pc, m_instr, m_cnt;
  bit          m_hold, m_err, m_boot, m_out;
  int          m_dly, rdy_left;
  int          cfg_rdy_lo = -1;
  int          cfg_dly    = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic bit m_req();
    return !m_boot && !m_err && !m_hold && !m_out;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 32'h0; m_cnt = 32'h0;
    m_hold = 0; m_err = 0; m_boot = 1; m_out = 0; m_dly = 0; rdy_left = -1;
  endtask

  task automatic check_all();
    chk("pc",      PC,                m_pc);
    chk("pcplus4", PCPlus4,           m_pc + 32'd4);
    chk("addr",    imem.addr,         m_pc);
    chk("req",     32'(imem.req),     32'(m_req()));
    chk("ivalid",  32'(InstrValid),   32'(m_hold));
    chk("instr",   Instr,             m_instr);
    chk("addrerr", 32'(AddrErr),      32'(m_err));
    chk("retire",  RetireCount,       m_cnt);
  endtask

  // one clock: drive core + memory inputs, advance, update model, compare
  task automatic step(input bit stall_v, input logic [31:0] npc_v);
    bit rq, rdy, rv, resp, commit;
    logic [31:0] rd;
    Stall   = stall_v;
    next_PC = npc_v;
    rq = m_req();
    if (rq) begin
      if (rdy_left < 0) rdy_left = (cfg_rdy_lo < 0) ? int'($urandom_range(0, 2)) : cfg_rdy_lo;
      rdy = (rdy_left == 0);
      if (rdy_left > 0) rdy_left--;
    end else begin
      rdy_left = -1;
      rdy = 1'($urandom_range(0, 1));
    end
    rd = $urandom;
    if (m_out) begin
      rv = (m_dly == 0);
      if (rv) rd = mem_word(m_pc);
    end else begin
      // stray responses outside a fetch must be ignored
      rv = !m_boot && ($urandom_range(0, 5) == 0);
    end
    imem.ready = rdy; imem.rvalid = rv; imem.rdata = rd;
    @(posedge clk); #1;
    resp   = m_out && rv;
    commit = m_hold && !stall_v && !m_err;
    if (m_out && !rv) m_dly--;
    if (resp) begin m_instr = rd; m_hold = 1; m_out = 0; end
    if (rq && rdy) begin
      m_out = 1;
      m_dly = (cfg_dly < 0) ? int'($urandom_range(0, 3)) : cfg_dly;
    end
    if (commit) begin
      m_cnt++;
      m_hold = 0;
      if (npc_v[1:0] == 2'b00) m_pc = npc_v;
      else                     m_err = 1;
    end
    m_boot = 0;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    Stall = 1'b0; next_PC = 32'h0;
    imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", PC, RST_PC);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_hold(input int bound);
    int i = 0;
    while (!m_hold && i < bound) begin
      step(1'($urandom_range(0, 1)), $urandom);
      i++;
    end
    chk("hold_reached", 32'(m_hold), 32'd1);
  endtask

  initial begin
    logic [31:0] base_cnt;
    // basic fetch: ready=1, rvalid one cycle after accept
    cfg_rdy_lo = 0; cfg_dly = 0;
    do_reset();
    step(0, 32'h0);
    chk("boot_req_rise", 32'(imem.req), 32'd1);
    step(0, 32'h0);
    chk("accept_no_valid", 32'(InstrValid), 32'd0);
    step(0, 32'h0);
    chk("first_ivalid", 32'(InstrValid), 32'd1);
    chk("first_instr", Instr, 32'h2008_0005);
    chk("first_pcplus4", PCPlus4, 32'h0040_0004);

    // stall in HOLD with next_PC toggling, then commit
    for (int i = 0; i < 5; i++) step(1, $urandom);
    chk("stall_pc", PC, RST_PC);
    chk("stall_instr", Instr, 32'h2008_0005);
    chk("stall_cnt", RetireCount, 32'd0);
    step(0, 32'h0040_0100);
    chk("commit_pc", PC, 32'h0040_0100);
    chk("commit_cnt", RetireCount, 32'd1);

    // slow memory: ready low 3 cycles, response 4 cycles after accept
    cfg_rdy_lo = 3; cfg_dly = 3;
    run_until_hold(40);
    chk("slow_instr", Instr, mem_word(32'h0040_0100));

    // misaligned target: sticky fault
    cfg_rdy_lo = 0; cfg_dly = 0;
    do_reset();
    run_until_hold(20);
    step(0, 32'h0040_0102);
    chk("err_flag", 32'(AddrErr), 32'd1);
    chk("err_pc", PC, 32'h0040_0000);
    chk("err_cnt", RetireCount, 32'd1);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), $urandom);
    chk("err_req_low", 32'(imem.req), 32'd0);
    chk("err_sticky", 32'(AddrErr), 32'd1);
    do_reset();
    chk("err_cleared", 32'(AddrErr), 32'd0);

    // async reset while waiting for a response
    cfg_rdy_lo = 0; cfg_dly = 5;
    run_until_hold(20);
    step(0, 32'h0040_0100);
    step(0, 32'h0);
    chk("wait_entered", 32'(m_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(imem.req), 32'd0);
    chk("async_pc", PC, RST_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_dly = 0;
    run_until_hold(20);
    chk("resume_instr", Instr, 32'h2008_0005);

    // sequential commits across the 32-bit wrap
    step(0, 32'hFFFF_FFE4);
    base_cnt = m_cnt;
    for (int i = 0; i < 10; i++) begin
      run_until_hold(20);
      if (m_pc == 32'hFFFF_FFFC) chk("wrap_pcplus4", PCPlus4, 32'h0000_0000);
      step(0, m_pc + 32'd4);
    end
    chk("wrap_pc", PC, 32'h0000_000C);
    chk("wrap_cnt", RetireCount - base_cnt, 32'd10);

    // randomized episodes
    cfg_rdy_lo = -1; cfg_dly = -1;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        logic [31:0] npc;
        npc = $urandom;
        if ($urandom_range(0, 49) != 0) npc[1:0] = 2'b00;
        step($urandom_range(0, 2) == 0, npc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
